mem_arbiter_2p: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_id_fifo.sv | 85 ++++++++
 rtl/mem_arbiter_2p.sv | 123 ++++++++++++
 tb/tb_mem_arbiter_2p.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port identifiers and the data width.
package mem_arb_pkg;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } port_id_t;

    localparam int MEM_ARB_DATA_W = 32;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Owner-ID FIFO: remembers which port issued each outstanding memory transaction.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic push_id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    port_id_t         id_q [DEPTH];
    port_id_t         id_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = id_q[rd_ptr_q];

    // Guard internally so a misbehaving caller cannot corrupt the count.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                id_d[gi] = id_q[gi];
                if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    id_d[gi] = port_id_t'(push_id_i);
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    id_q[gi] <= INSTR;
                end else begin
                    id_q[gi] <= id_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one req/gnt/rvalid memory between instruction-fetch and load/store ports.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise DATA has fixed priority.
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADR_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      instr_req_i,
    input  logic [ADR_W-1:0]          instr_adr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [MEM_ARB_DATA_W-1:0] instr_read_o,
    input  logic                      data_req_i,
    input  logic [ADR_W-1:0]          data_adr_i,
    input  logic [MEM_ARB_DATA_W-1:0] data_write_i,
    input  logic                      data_write_enable_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [MEM_ARB_DATA_W-1:0] data_read_o,
    output logic                      mem_req_o,
    output logic [ADR_W-1:0]          mem_adr_o,
    output logic [MEM_ARB_DATA_W-1:0] mem_write_o,
    output logic                      mem_write_enable_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [MEM_ARB_DATA_W-1:0] mem_read_i,
    output logic                      err_o
);

    logic fifo_full;
    logic fifo_empty;
    logic head_id;
    logic instr_elig;
    logic data_elig;
    logic data_on_contention;
    logic data_wins;
    logic accept;
    logic pop;
    logic err_q, err_d;

    // A full FIFO blocks new grants even when a response retires in the same cycle.
    assign instr_elig = instr_req_i & ~fifo_full;
    assign data_elig  = data_req_i & ~fifo_full;
    assign data_wins  = data_elig & (~instr_elig | data_on_contention);
    assign accept     = mem_req_o & mem_gnt_i;
    assign pop        = mem_rvalid_i & ~fifo_empty;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_id_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = data_wins ? DATA : INSTR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= DATA;
        end else begin
            last_q <= last_d;
        end
    end

    assign data_on_contention = (last_q == INSTR);
`else
    assign data_on_contention = 1'b1;
`endif

    always_comb begin
        mem_req_o          = instr_elig | data_elig;
        mem_adr_o          = '0;
        mem_write_o        = '0;
        mem_write_enable_o = 1'b0;
        if (data_wins) begin
            mem_adr_o          = data_adr_i;
            mem_write_o        = data_write_i;
            mem_write_enable_o = data_write_enable_i;
        end else if (instr_elig) begin
            mem_adr_o = instr_adr_i;
        end
    end

    assign instr_gnt_o = mem_gnt_i & instr_elig & ~data_wins;
    assign data_gnt_o  = mem_gnt_i & data_wins;

    assign instr_rvalid_o = pop & (port_id_t'(head_id) == INSTR);
    assign data_rvalid_o  = pop & (port_id_t'(head_id) == DATA);
    assign instr_read_o   = mem_read_i;
    assign data_read_o    = mem_read_i;

    always_comb begin
        err_d = err_q | (mem_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    mem_arb_id_fifo #(
        .DEPTH(DEPTH)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (accept),
        .push_id_i (data_wins),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head_id)
    );

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a response scoreboard and a small downstream memory model.
module tb_mem_arbiter_2p;
    import mem_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int ADR_W = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              instr_req_i = 1'b0;
    logic [ADR_W-1:0]  instr_adr_i = '0;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [31:0]       instr_read_o;
    logic              data_req_i = 1'b0;
    logic [ADR_W-1:0]  data_adr_i = '0;
    logic [31:0]       data_write_i = '0;
    logic              data_write_enable_i = 1'b0;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [31:0]       data_read_o;
    logic              mem_req_o;
    logic [ADR_W-1:0]  mem_adr_o;
    logic [31:0]       mem_write_o;
    logic              mem_write_enable_o;
    logic              mem_gnt_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [31:0]       mem_read_i = '0;
    logic              err_o;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] pend_q [$];
    logic [31:0] mem_model [0:1023];
    int          errors = 0;
    int          checks = 0;
    bit          hold_rv = 1'b0;
    bit          force_rv = 1'b0;
    logic        exp_data;

    always #5 clk = ~clk;

    mem_arbiter_2p #(
        .DEPTH(DEPTH),
        .ADR_W(ADR_W)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .instr_req_i         (instr_req_i),
        .instr_adr_i         (instr_adr_i),
        .instr_gnt_o         (instr_gnt_o),
        .instr_rvalid_o      (instr_rvalid_o),
        .instr_read_o        (instr_read_o),
        .data_req_i          (data_req_i),
        .data_adr_i          (data_adr_i),
        .data_write_i        (data_write_i),
        .data_write_enable_i (data_write_enable_i),
        .data_gnt_o          (data_gnt_o),
        .data_rvalid_o       (data_rvalid_o),
        .data_read_o         (data_read_o),
        .mem_req_o           (mem_req_o),
        .mem_adr_o           (mem_adr_o),
        .mem_write_o         (mem_write_o),
        .mem_write_enable_o  (mem_write_enable_o),
        .mem_gnt_i           (mem_gnt_i),
        .mem_rvalid_i        (mem_rvalid_i),
        .mem_read_i          (mem_read_i),
        .err_o               (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic port, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic dwe, input logic [31:0] dwd);
        instr_req_i         = ir;
        instr_adr_i         = ia;
        data_req_i          = dr;
        data_adr_i          = da;
        data_write_enable_i = dwe;
        data_write_i        = dwd;
        #1;
    endtask

    // One clock of the downstream memory: accepted requests respond one cycle later.
    task automatic tick();
        logic        acc;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        acc = mem_req_o & mem_gnt_i;
        we  = mem_write_enable_o;
        a   = mem_adr_o;
        wd  = mem_write_o;
        @(posedge clk);
        #1;
        if (acc) begin
            if (we) begin
                mem_model[a[11:2]] = wd;
                pend_q.push_back(32'h0);
            end else begin
                pend_q.push_back(mem_model[a[11:2]]);
            end
        end
        if (force_rv) begin
            mem_rvalid_i = 1'b1;
            mem_read_i   = 32'h5555_5555;
        end else if (!hold_rv && pend_q.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_read_i   = pend_q.pop_front();
        end else begin
            mem_rvalid_i = 1'b0;
            mem_read_i   = 32'h0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (instr_rvalid_o || data_rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: instr_rvalid=%b data_rvalid=%b, none expected",
                         instr_rvalid_o, data_rvalid_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr_rvalid_o !== ~mon_e.port || data_rvalid_o !== mon_e.port ||
                    (mon_e.port ? data_read_o : instr_read_o) !== mon_e.data) begin
                    errors++;
                    $display("FAIL rsp_route: instr_rvalid=%b data_rvalid=%b read=%h expected port=%0d data=%h",
                             instr_rvalid_o, data_rvalid_o, mon_e.port ? data_read_o : instr_read_o,
                             mon_e.port, mon_e.data);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        mem_model[32'h010 >> 2] = 32'h0000_0013;
        mem_model[32'h020 >> 2] = 32'h1111_0001;
        mem_model[32'h200 >> 2] = 32'h2222_0002;
        for (int k = 0; k < 5; k++) mem_model[(32'h40 + 4 * k) >> 2] = 32'hA0 + k;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_err", err_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_instr_rvalid", instr_rvalid_o, 0);
        chk("rst_data_rvalid", data_rvalid_o, 0);
        rst_i     = 1'b0;
        mem_gnt_i = 1'b1;
        #1;

        // Contention for 4 cycles, then DATA drops
        for (int c = 0; c < 4; c++) begin
            drive(1, 32'h20, 1, 32'h200, 0, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_data = ((c % 2) == 1);
`else
            exp_data = 1'b1;
`endif
            chk("cont_instr_gnt", instr_gnt_o, !exp_data);
            chk("cont_data_gnt", data_gnt_o, exp_data);
            chk("cont_adr", mem_adr_o, exp_data ? 32'h200 : 32'h20);
            expect_resp(exp_data, exp_data ? 32'h2222_0002 : 32'h1111_0001);
            tick();
        end
        drive(1, 32'h20, 0, 0, 0, 0);
        chk("cont_tail_instr_gnt", instr_gnt_o, 1);
        expect_resp(INSTR, 32'h1111_0001);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Instruction fetch only
        drive(1, 32'h10, 0, 0, 0, 0);
        chk("fetch_mem_req", mem_req_o, 1);
        chk("fetch_adr", mem_adr_o, 32'h10);
        chk("fetch_gnt", instr_gnt_o, 1);
        chk("fetch_data_gnt", data_gnt_o, 0);
        chk("fetch_we", mem_write_enable_o, 0);
        expect_resp(INSTR, 32'h13);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("fetch_rvalid", instr_rvalid_o, 1);
        chk("fetch_data_rvalid", data_rvalid_o, 0);
        chk("fetch_read", instr_read_o, 32'h13);
        tick();

        // Store then load the same word
        drive(0, 0, 1, 32'h100, 1, 32'hDEAD_BEEF);
        chk("store_gnt", data_gnt_o, 1);
        chk("store_we", mem_write_enable_o, 1);
        chk("store_wdata", mem_write_o, 32'hDEAD_BEEF);
        expect_resp(DATA, 32'h0);
        tick();
        drive(0, 0, 1, 32'h100, 0, 0);
        chk("load_gnt", data_gnt_o, 1);
        chk("load_we", mem_write_enable_o, 0);
        expect_resp(DATA, 32'hDEAD_BEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Fill the ID FIFO with responses held off
        hold_rv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0) begin
                drive(1, 32'h40 + 4 * k, 0, 0, 0, 0);
                chk("fill_instr_gnt", instr_gnt_o, 1);
            end else begin
                drive(0, 0, 1, 32'h40 + 4 * k, 0, 0);
                chk("fill_data_gnt", data_gnt_o, 1);
            end
            expect_resp((k % 2) == 1, 32'hA0 + k);
            tick();
        end
        drive(1, 32'h50, 0, 0, 0, 0);
        chk("full_mem_req", mem_req_o, 0);
        chk("full_instr_gnt", instr_gnt_o, 0);
        hold_rv = 1'b0;
        tick();
        chk("full_pop_mem_req", mem_req_o, 0);
        chk("full_pop_instr_gnt", instr_gnt_o, 0);
        tick();
        chk("after_full_gnt", instr_gnt_o, 1);
        expect_resp(INSTR, 32'hA4);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 20 && (pend_q.size() > 0 || mem_rvalid_i); n++) tick();
        chk("drain_done", pend_q.size(), 0);

        // Spurious response with nothing outstanding
        chk("err_before_spurious", err_o, 0);
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        chk("spur_instr_rvalid", instr_rvalid_o, 0);
        chk("spur_data_rvalid", data_rvalid_o, 0);
        tick();
        chk("spur_err_set", err_o, 1);
        repeat (3) tick();
        chk("spur_err_sticky", err_o, 1);

        // Reset with two transactions in flight
        hold_rv = 1'b1;
        drive(1, 32'h10, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 32'h200, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        #1;
        chk("inflight_rst_err_clr", err_o, 0);
        repeat (2) tick();
        rst_i   = 1'b0;
        hold_rv = 1'b0;
        tick();
        chk("late_instr_rvalid", instr_rvalid_o, 0);
        chk("late_data_rvalid", data_rvalid_o, 0);
        tick();
        chk("late_err_set", err_o, 1);
        repeat (2) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
